fft_stage_ctrl: RTL

- Sequencer for an in-place, iterative radix-2 DIT FFT built around one pipelined butterfly unit (4-cycle latency, Q1.15 complex_t from fft_consts).
- Per stage, it issues one butterfly per cycle: A/B read addresses and a twiddle ROM index. It delays the addresses to generate the matching write-back strobe.
- Between stages it drains the pipeline so that stage s+1 never reads stale data.
- Sits between the sample RAM / twiddle ROM and the butterfly. Data arrive in bit-reversed order; loading them is not this block's job.

---
 rtl/fft_stage_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/fft_stage_ctrl.sv
// fft_stage_ctrl: radix-2 DIT FFT stage sequencer with write-back delay line; define FFT_CTRL_STALL_EN to add a stall input
module fft_stage_ctrl #(
    parameter int N_LOG2  = 4,
    parameter int RD_LAT  = 1,
    parameter int BFU_LAT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
`ifdef FFT_CTRL_STALL_EN
    input  logic                      stall,
`endif
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(N_LOG2)-1:0] stage,
    output logic                      rd_en,
    output logic [N_LOG2-1:0]         rd_addr_a,
    output logic [N_LOG2-1:0]         rd_addr_b,
    output logic [N_LOG2-2:0]         tw_addr,
    output logic                      wr_en,
    output logic [N_LOG2-1:0]         wr_addr_a,
    output logic [N_LOG2-1:0]         wr_addr_b
);
    localparam int PIPE_LAT = RD_LAT + BFU_LAT;
    localparam int SW = $clog2(N_LOG2);
    localparam int KW = N_LOG2 - 1;
    localparam int DW = $clog2(PIPE_LAT + 1);
    localparam logic [SW-1:0] LAST_STAGE = SW'(N_LOG2 - 1);
    localparam logic [KW-1:0] K_LAST = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic [KW-1:0]   k;
    logic [DW-1:0]   dcnt;
    logic            hold;
    logic [2*N_LOG2:0] dly [PIPE_LAT];

`ifdef FFT_CTRL_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    // {a, b, tw} for butterfly k of stage s
    function automatic logic [3*N_LOG2-2:0] bfly(input int s, input int kk);
        int j, a;
        j = kk & ((1 << s) - 1);
        a = ((kk >> s) << (s + 1)) | j;
        return {N_LOG2'(a), N_LOG2'(a + (1 << s)), (N_LOG2-1)'(j << (N_LOG2 - 1 - s))};
    endfunction

    // Stage/butterfly sequencer; read outputs are loaded one cycle ahead so they line up with the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            stage     <= '0;
            k         <= '0;
            dcnt      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr_a <= '0;
            rd_addr_b <= '0;
            tw_addr   <= '0;
        end else begin
            done  <= 1'b0;
            rd_en <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    busy  <= 1'b1;
                    stage <= '0;
                    k     <= '0;
                    rd_en <= 1'b1;
                    {rd_addr_a, rd_addr_b, tw_addr} <= bfly(0, 0);
                end
                RUN: if (!hold) begin
                    if (k == K_LAST) begin
                        state <= DRAIN;
                        dcnt  <= DW'(PIPE_LAT);
                    end else begin
                        k     <= k + KW'(1);
                        rd_en <= 1'b1;
                        {rd_addr_a, rd_addr_b, tw_addr} <= bfly(int'(stage), int'(k) + 1);
                    end
                end
                DRAIN: if (dcnt != DW'(1)) begin
                    dcnt <= dcnt - DW'(1);
                end else if (stage != LAST_STAGE) begin
                    state <= RUN;
                    stage <= stage + SW'(1);
                    k     <= '0;
                    rd_en <= 1'b1;
                    {rd_addr_a, rd_addr_b, tw_addr} <= bfly(int'(stage) + 1, 0);
                end else begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read strobe and addresses delayed by the full read + butterfly latency become the write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PIPE_LAT; i++) dly[i] <= '0;
        end else begin
            dly[0] <= {rd_en, rd_addr_a, rd_addr_b};
            for (int i = 1; i < PIPE_LAT; i++) dly[i] <= dly[i-1];
        end
    end

    assign {wr_en, wr_addr_a, wr_addr_b} = dly[PIPE_LAT-1];
endmodule
